// File: rtl/mem_access_sequencer.sv
// Sequences SPARC-style loads, stores and SWAP onto a 32-bit word-wide RAM.
// Sub-word lanes are big-endian: byte offset 0 lives in bits 31:24.

module mem_access_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic        be,
    output logic [7:0]  wdata
);
    localparam logic [1:0] LIDX = LANE[1:0];

    // size: 0 byte, 1 halfword, 2/3 full word
    always_comb begin
        be    = 1'b0;
        wdata = 8'h00;
        unique case (size)
            2'd0: begin
                be    = (offset == LIDX);
                wdata = data[7:0];
            end
            2'd1: begin
                be    = (offset[1] == LIDX[1]);
                wdata = LIDX[0] ? data[7:0] : data[15:8];
            end
            default: begin
                be    = 1'b1;
                wdata = data[31-8*LANE -: 8];
            end
        endcase
    end
endmodule

module mem_access_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [5:0]        OpCode,
    input  logic [ADDR_W-1:0] MAR_Address,
    input  logic [63:0]       MDR_DataIn,
    output logic [63:0]       MDR_DataOut,
    output logic              Busy,
    output logic              Done,
    output logic              AlignErr,
    output logic              Ram_Enable,
    output logic              Ram_Write,
    output logic [3:0]        Ram_ByteEn,
    output logic [ADDR_W-3:0] Ram_Address,
    output logic [31:0]       Ram_WData,
    input  logic [31:0]       Ram_RData
);
    localparam int NUM_LANES = 4;
    localparam int WA_W      = ADDR_W - 2;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_SWAP = 6'b001111;

    typedef enum logic [2:0] {IDLE, ACC1, WAIT1, ACC2, WAIT2, FIN} state_t;

    typedef struct packed {
        logic       write;
        logic       swap;
        logic       two;
        logic       sext;
        logic [1:0] size;
    } op_info_t;

    function automatic logic [1:0] op_size(input logic [5:0] op);
        case (op)
            OP_LDUH, OP_LDSH, OP_STH: op_size = 2'd1;
            OP_LD, OP_ST, OP_SWAP:    op_size = 2'd2;
            OP_LDD, OP_STD:           op_size = 2'd3;
            default:                  op_size = 2'd0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_LD, OP_LDUB, OP_LDUH, OP_LDD, OP_ST, OP_STB, OP_STH, OP_STD,
            OP_LDSB, OP_LDSH, OP_SWAP: op_legal = 1'b1;
            default:                   op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = |a[1:0];
            2'd3:    misaligned = |a;
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic op_info_t decode(input logic [5:0] op);
        op_info_t d;
        d.size  = op_size(op);
        d.write = (op == OP_ST) || (op == OP_STB) || (op == OP_STH) || (op == OP_STD);
        d.swap  = (op == OP_SWAP);
        d.two   = (op == OP_LDD) || (op == OP_STD) || (op == OP_SWAP);
        d.sext  = (op == OP_LDSB) || (op == OP_LDSH);
        return d;
    endfunction

    state_t              state, state_nx;
    logic [5:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [63:0]         din_q;
    logic                err_q;
    logic [63:0]         dout_q;

    op_info_t            info;
    logic                start_err;
    logic [WA_W-1:0]     wa;
    logic                second_word;
    logic [31:0]         st_data;
    logic                acc_on, acc_wr;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [31:0]         ld_word;

    logic [NUM_LANES-1:0]        lane_be;
    logic [NUM_LANES-1:0][7:0]   lane_wd;

    assign info        = decode(op_q);
    assign start_err   = !op_legal(OpCode) || misaligned(op_size(OpCode), MAR_Address[2:0]);
    assign wa          = addr_q[ADDR_W-1:2];
    // LDD/STD step to the next word on the second access; SWAP stays put
    assign second_word = (state == ACC2) && !info.swap;
    assign st_data     = second_word ? din_q[31:0] : din_q[63:32];
    assign MDR_DataOut = dout_q;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            mem_access_lane #(.LANE(i)) u_lane (
                .size   (info.size),
                .offset (addr_q[1:0]),
                .data   (st_data),
                .be     (lane_be[NUM_LANES-1-i]),
                .wdata  (lane_wd[NUM_LANES-1-i])
            );
        end
    endgenerate

    always_comb begin
        rd_byte = Ram_RData[{~addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? Ram_RData[15:0] : Ram_RData[31:16];
        case (info.size)
            2'd0:    ld_word = {{24{info.sext & rd_byte[7]}}, rd_byte};
            2'd1:    ld_word = {{16{info.sext & rd_half[15]}}, rd_half};
            default: ld_word = Ram_RData;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            op_q   <= '0;
            addr_q <= '0;
            din_q  <= '0;
            err_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && Start) begin
                op_q   <= OpCode;
                addr_q <= MAR_Address;
                din_q  <= MDR_DataIn;
                err_q  <= start_err;
                dout_q <= '0;
            end
            if (state == WAIT1 && !info.write)
                dout_q[63:32] <= ld_word;
            if (state == WAIT2 && !info.write && !info.swap)
                dout_q[31:0] <= Ram_RData;
        end
    end

    always_comb begin
        state_nx    = state;
        acc_on      = (state == ACC1) || (state == ACC2);
        acc_wr      = ((state == ACC1) && info.write) ||
                      ((state == ACC2) && (info.write || info.swap));
        Busy        = (state != IDLE);
        Done        = (state == FIN);
        AlignErr    = (state == FIN) && err_q;
        Ram_Enable  = acc_on;
        Ram_Write   = acc_wr;
        Ram_ByteEn  = 4'b0000;
        Ram_WData   = 32'h0;
        Ram_Address = '0;
        if (acc_on)
            Ram_Address = second_word ? wa + WA_W'(1) : wa;
        if (acc_wr) begin
            Ram_ByteEn = lane_be;
            Ram_WData  = lane_wd;
        end
        unique case (state)
            IDLE:    if (Start) state_nx = start_err ? FIN : ACC1;
            ACC1:    state_nx = WAIT1;
            WAIT1:   state_nx = info.two ? ACC2 : FIN;
            ACC2:    state_nx = WAIT2;
            WAIT2:   state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed vector table, reset corners, and
// random operations scored against a byte-level reference model of the RAM.

module tb_mem_access_sequencer;
    localparam int ADDR_W = 8;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Start = 1'b0;
    logic [5:0]        OpCode = '0;
    logic [ADDR_W-1:0] MAR_Address = '0;
    logic [63:0]       MDR_DataIn = '0;
    logic [63:0]       MDR_DataOut;
    logic              Busy, Done, AlignErr, Ram_Enable, Ram_Write;
    logic [3:0]        Ram_ByteEn;
    logic [ADDR_W-3:0] Ram_Address;
    logic [31:0]       Ram_WData;
    logic [31:0]       ram_rdata;

    mem_access_sequencer #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .OpCode(OpCode),
        .MAR_Address(MAR_Address), .MDR_DataIn(MDR_DataIn), .MDR_DataOut(MDR_DataOut),
        .Busy(Busy), .Done(Done), .AlignErr(AlignErr), .Ram_Enable(Ram_Enable),
        .Ram_Write(Ram_Write), .Ram_ByteEn(Ram_ByteEn), .Ram_Address(Ram_Address),
        .Ram_WData(Ram_WData), .Ram_RData(ram_rdata)
    );

    always #5 Clk = ~Clk;

    // Word RAM with one-cycle read latency; preload port used by the stimulus
    logic [31:0] ram [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
            ram_rdata <= 32'h0;
        end else begin
            if (pre_en) ram[pre_addr] <= pre_data;
            if (Ram_Enable) begin
                if (Ram_Write) begin
                    for (int b = 0; b < 4; b++)
                        if (Ram_ByteEn[b]) ram[Ram_Address][8*b +: 8] <= Ram_WData[8*b +: 8];
                end else begin
                    ram_rdata <= ram[Ram_Address];
                end
            end
        end
    end

    typedef logic [42:0] acc_t;   // {write, word address, byte enables, write data}

    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_mem [64];
    acc_t        got_acc[$];
    acc_t        exp_acc[$];
    int          got_lat, exp_lat;
    logic        got_err, exp_err;
    logic [63:0] got_dout, hold_dout, exp_dout;
    bit          busy_bad, quiet_bad, timed_out, abort_bad;

    function automatic acc_t mk(input logic wr, input logic [5:0] a, input logic [3:0] be,
                                input logic [31:0] wd);
        return {wr, a, be, wd};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge Clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d; ref_mem[a] = d;
        @(negedge Clk);
        pre_en = 1'b0;
    endtask

    // Start is held high and the request inputs scrambled while busy:
    // the operation must run on the values captured at acceptance.
    task automatic do_op(input logic [5:0] op, input logic [7:0] addr, input logic [63:0] din);
        got_acc.delete();
        busy_bad = 0; quiet_bad = 0; timed_out = 1;
        got_lat = 0; got_err = 1'b0; got_dout = '0;
        @(negedge Clk);
        if (Busy) busy_bad = 1;
        Start = 1'b1; OpCode = op; MAR_Address = addr; MDR_DataIn = din;
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            OpCode = 6'($urandom); MAR_Address = 8'($urandom); MDR_DataIn = {$urandom, $urandom};
            if (!Busy) busy_bad = 1;
            if (Ram_Enable) got_acc.push_back({Ram_Write, Ram_Address, Ram_ByteEn, Ram_WData});
            if (!Done && AlignErr) quiet_bad = 1;
            if (Done) begin
                got_lat = c; got_err = AlignErr; got_dout = MDR_DataOut; timed_out = 0;
                Start = 1'b0;
                break;
            end
        end
        Start = 1'b0;
        @(negedge Clk);
        hold_dout = MDR_DataOut;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) m = m | (32'hFF << (8*b));
        exp_acc.push_back(mk(1'b1, a, be, wd));
        ref_mem[a] = (ref_mem[a] & ~m) | (wd & m);
    endtask

    task automatic model(input logic [5:0] op, input logic [7:0] addr, input logic [63:0] din);
        logic [5:0]  wa, wb;
        int          off, size;
        logic [31:0] w, v;
        exp_acc.delete();
        exp_dout = '0; exp_err = 1'b0; exp_lat = 1;
        wa = addr[7:2]; wb = wa + 6'd1; off = int'(addr[1:0]); w = ref_mem[wa];
        case (op)
            6'h00, 6'h04, 6'h0F: size = 4;
            6'h01, 6'h05, 6'h09: size = 1;
            6'h02, 6'h06, 6'h0A: size = 2;
            6'h03, 6'h07:        size = 8;
            default:             size = 0;
        endcase
        if (size == 0 || (int'(addr) % size) != 0) begin
            exp_err = 1'b1;
            return;
        end
        case (op)
            6'h00: begin exp_acc.push_back(mk(1'b0, wa, 4'h0, 32'h0)); exp_dout = {w, 32'h0}; end
            6'h01, 6'h09: begin
                v = (w >> (8*(3-off))) & 32'hFF;
                if (op == 6'h09 && v >= 32'h80) v = v | 32'hFFFFFF00;
                exp_acc.push_back(mk(1'b0, wa, 4'h0, 32'h0)); exp_dout = {v, 32'h0};
            end
            6'h02, 6'h0A: begin
                v = (w >> (16 - 8*off)) & 32'hFFFF;
                if (op == 6'h0A && v >= 32'h8000) v = v | 32'hFFFF0000;
                exp_acc.push_back(mk(1'b0, wa, 4'h0, 32'h0)); exp_dout = {v, 32'h0};
            end
            6'h03: begin
                exp_acc.push_back(mk(1'b0, wa, 4'h0, 32'h0));
                exp_acc.push_back(mk(1'b0, wb, 4'h0, 32'h0));
                exp_dout = {w, ref_mem[wb]};
            end
            6'h04: model_write(wa, 4'hF, din[63:32]);
            6'h05: model_write(wa, 4'(8 >> off), {4{din[39:32]}});
            6'h06: model_write(wa, (off == 2) ? 4'b0011 : 4'b1100, {2{din[47:32]}});
            6'h07: begin model_write(wa, 4'hF, din[63:32]); model_write(wb, 4'hF, din[31:0]); end
            default: begin
                exp_acc.push_back(mk(1'b0, wa, 4'h0, 32'h0));
                exp_dout = {w, 32'h0};
                model_write(wa, 4'hF, din[63:32]);
            end
        endcase
        exp_lat = (exp_acc.size() == 2) ? 5 : 3;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [7:0]  addr;
        logic [63:0] din;
        logic [5:0]  pre_wa;
        logic [31:0] pre_val;
        logic [63:0] e_dout;
        logic        e_err;
        int          e_lat;
        int          e_nacc;
        acc_t        e_a0;
        acc_t        e_a1;
    } vec_t;

    vec_t       tbl [9];
    logic [5:0] ops [13];

    initial begin
        tbl[0] = '{6'h00, 8'h10, 64'h0, 6'd4, 32'hDEADBEEF, 64'hDEADBEEF_00000000, 1'b0, 3, 1,
                   mk(1'b0, 6'd4, 4'h0, 32'h0), '0};
        tbl[1] = '{6'h09, 8'h13, 64'h0, 6'd4, 32'h000000F0, 64'hFFFFFFF0_00000000, 1'b0, 3, 1,
                   mk(1'b0, 6'd4, 4'h0, 32'h0), '0};
        tbl[2] = '{6'h01, 8'h13, 64'h0, 6'd4, 32'h000000F0, 64'h000000F0_00000000, 1'b0, 3, 1,
                   mk(1'b0, 6'd4, 4'h0, 32'h0), '0};
        tbl[3] = '{6'h06, 8'h22, 64'h0000ABCD_00000000, 6'd8, 32'h0, 64'h0, 1'b0, 3, 1,
                   mk(1'b1, 6'd8, 4'b0011, 32'hABCDABCD), '0};
        tbl[4] = '{6'h07, 8'h08, 64'h11111111_22222222, 6'd2, 32'h0, 64'h0, 1'b0, 5, 2,
                   mk(1'b1, 6'd2, 4'hF, 32'h11111111), mk(1'b1, 6'd3, 4'hF, 32'h22222222)};
        tbl[5] = '{6'h0F, 8'h04, 64'hCAFEF00D_00000000, 6'd1, 32'h12345678, 64'h12345678_00000000,
                   1'b0, 5, 2, mk(1'b0, 6'd1, 4'h0, 32'h0), mk(1'b1, 6'd1, 4'hF, 32'hCAFEF00D)};
        tbl[6] = '{6'h00, 8'h02, 64'h0, 6'd0, 32'h0, 64'h0, 1'b1, 1, 0, '0, '0};
        tbl[7] = '{6'h0C, 8'h10, 64'h0, 6'd0, 32'h0, 64'h0, 1'b1, 1, 0, '0, '0};
        tbl[8] = '{6'h0A, 8'h16, 64'h0, 6'd5, 32'h00008001, 64'hFFFF8001_00000000, 1'b0, 3, 1,
                   mk(1'b0, 6'd5, 4'h0, 32'h0), '0};
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                6'h09, 6'h0A, 6'h0F, 6'h0C, 6'h08};
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        #2 Reset = 1'b1;
        #10;
        chk("reset_ctrl", {Busy, Done, AlignErr, Ram_Enable, Ram_Write, Ram_ByteEn,
                           Ram_Address, Ram_WData}, 64'h0);
        chk("reset_dout", MDR_DataOut, 64'h0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            preload(tbl[i].pre_wa, tbl[i].pre_val);
            do_op(tbl[i].op, tbl[i].addr, tbl[i].din);
            chk($sformatf("vec%0d_lat", i), 64'(got_lat), 64'(tbl[i].e_lat));
            chk($sformatf("vec%0d_err", i), 64'(got_err), 64'(tbl[i].e_err));
            chk($sformatf("vec%0d_dout", i), got_dout, tbl[i].e_dout);
            chk($sformatf("vec%0d_nacc", i), 64'(got_acc.size()), 64'(tbl[i].e_nacc));
            if (got_acc.size() > 0 && tbl[i].e_nacc > 0)
                chk($sformatf("vec%0d_acc0", i), 64'(got_acc[0]), 64'(tbl[i].e_a0));
            if (got_acc.size() > 1 && tbl[i].e_nacc > 1)
                chk($sformatf("vec%0d_acc1", i), 64'(got_acc[1]), 64'(tbl[i].e_a1));
            chk($sformatf("vec%0d_busy", i), 64'(busy_bad), 64'h0);
            chk($sformatf("vec%0d_hold", i), hold_dout, got_dout);
        end

        // Reset in WAIT1 of an STD: no second write, no Done, then normal restart
        @(negedge Clk);
        Start = 1'b1; OpCode = 6'h07; MAR_Address = 8'h08; MDR_DataIn = 64'h33333333_44444444;
        @(negedge Clk);
        Start = 1'b0;
        chk("mid_acc1", {Ram_Enable, Ram_Write}, 64'h3);
        @(negedge Clk);
        chk("mid_wait1", {Busy, Ram_Enable}, 64'h2);
        Reset = 1'b1;
        #1;
        chk("mid_reset_ctrl", {Busy, Done, AlignErr, Ram_Enable, Ram_Write, Ram_ByteEn,
                               Ram_Address, Ram_WData}, 64'h0);
        chk("mid_reset_dout", MDR_DataOut, 64'h0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        abort_bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (Ram_Enable || Done || Busy) abort_bad = 1;
        end
        chk("abort_quiet", 64'(abort_bad), 64'h0);
        preload(6'd8, 32'h0BADF00D);
        do_op(6'h00, 8'h20, 64'h0);
        chk("post_reset_lat", 64'(got_lat), 64'd3);
        chk("post_reset_dout", got_dout, 64'h0BADF00D_00000000);

        for (int n = 0; n < 120; n++) begin
            logic [5:0]  op;
            logic [7:0]  addr;
            logic [63:0] din;
            int          r;
            op = ops[$urandom_range(0, 12)];
            addr = 8'($urandom);
            r = $urandom_range(0, 2);
            if (r == 1) addr[0] = 1'b0;
            if (r == 2) addr[2:0] = 3'b000;
            din = {$urandom, $urandom};
            preload(addr[7:2], $urandom);
            preload(addr[7:2] + 6'd1, $urandom);
            model(op, addr, din);
            do_op(op, addr, din);
            chk($sformatf("rnd%0d_op%h_a%h_lat", n, op, addr), 64'(got_lat), 64'(exp_lat));
            chk($sformatf("rnd%0d_op%h_a%h_err", n, op, addr), 64'(got_err), 64'(exp_err));
            chk($sformatf("rnd%0d_op%h_a%h_dout", n, op, addr), got_dout, exp_dout);
            chk($sformatf("rnd%0d_op%h_a%h_nacc", n, op, addr), 64'(got_acc.size()),
                64'(exp_acc.size()));
            for (int k = 0; k < got_acc.size() && k < exp_acc.size(); k++)
                chk($sformatf("rnd%0d_op%h_a%h_acc%0d", n, op, addr, k), 64'(got_acc[k]),
                    64'(exp_acc[k]));
            chk($sformatf("rnd%0d_flags", n), {61'h0, busy_bad, quiet_bad, timed_out}, 64'h0);
            chk($sformatf("rnd%0d_hold", n), hold_dout, got_dout);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the byte-address width.
REQ-002 SHALL have port Clk  in  1  rising-edge clock.
REQ-003 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port Start  in  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have port OpCode  in  6  SPARC op3:
  - 000000 LD, 000001 LDUB, 000010 LDUH, 000011 LDD
  - 000100 ST, 000101 STB, 000110 STH, 000111 STD
  - 001001 LDSB, 001010 LDSH, 001111 SWAP
REQ-006 SHALL have port MAR_Address  in  ADDR_W  byte address.
REQ-007 SHALL have port MDR_DataIn  in  64  store data: [63:32] first/only word, [31:0] second word (STD only).
REQ-008 SHALL have port MDR_DataOut  out  64  load result: [63:32] first/only word, [31:0] second word (LDD only).
REQ-009 SHALL have port Busy  out  1  high from the cycle after Start is accepted until Done.
REQ-010 SHALL have port Done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port AlignErr  out  1  valid with Done; high on misaligned address or unsupported opcode.
REQ-012 SHALL have port Ram_Enable  out  1  RAM access strobe.
REQ-013 SHALL have port Ram_Write  out  1  write when 1, read when 0.
REQ-014 SHALL have port Ram_ByteEn  out  4  write lanes; bit3 = bits 31:24.
REQ-015 SHALL have port Ram_Address  out  ADDR_W-2  word address.
REQ-016 SHALL have port Ram_WData  out  32  RAM write data.
REQ-017 SHALL have port Ram_RData  in  32  RAM read data, valid the cycle after a read strobe.

Function
REQ-018 SHALL implement FSM states IDLE, ACC1, WAIT1, ACC2, WAIT2, FIN.
REQ-019 IDLE with Start=1 SHALL latch OpCode, MAR_Address and MDR_DataIn, then go to ACC1.
  - Error case: misaligned address or unsupported opcode SHALL go directly to FIN with AlignErr=1 and no RAM access.
  - Word alignment: address[1:0]=0; halfword: address[0]=0; doubleword: address[2:0]=0.
REQ-020 Start SHALL be ignored outside IDLE.
REQ-021 ACC1 and ACC2 SHALL assert Ram_Enable for exactly one cycle each; Ram_Enable SHALL be 0 in all other states.
REQ-022 WAIT1 and WAIT2 SHALL capture Ram_RData for reads.
REQ-023 After WAIT1, LDD, STD and SWAP SHALL go to ACC2; all other opcodes SHALL go to FIN.
REQ-024 WAIT2 SHALL go to FIN; FIN SHALL pulse Done and return to IDLE.
REQ-025 Latency from the Start-accepting edge to Done SHALL be:
  - 3 cycles for single accesses
  - 5 cycles for LDD, STD and SWAP
  - 1 cycle for errors
REQ-026 Byte order SHALL be big-endian: byte offset 0 occupies bits 31:24.
  - Ram_Address = address[ADDR_W-1:2]
  - ACC2 for LDD/STD SHALL use word address + 1.
  - Word address arithmetic SHALL wrap modulo 2^(ADDR_W-2).
REQ-027 Byte and halfword loads SHALL extract the selected lane into MDR_DataOut[39:32] (byte) or [47:32] (halfword).
  - LDUB/LDUH SHALL zero-extend into bits 63:32.
  - LDSB/LDSH SHALL sign-extend into bits 63:32.
REQ-028 Byte and halfword stores SHALL replicate the low byte/halfword of MDR_DataIn[63:32] across Ram_WData.
  - Ram_ByteEn SHALL select only the addressed lane(s).
  - ST/STD SHALL drive Ram_ByteEn=1111; reads SHALL drive 0000.
REQ-029 SWAP SHALL run as a read-modify-write:
  - ACC1 reads the word.
  - ACC2 writes MDR_DataIn[63:32] to the same word address, ByteEn=1111.
  - The old word SHALL be returned in MDR_DataOut[63:32].
REQ-030 MDR_DataOut bits not written by the current operation SHALL be zero.
REQ-031 MDR_DataOut SHALL hold its value from FIN until the next accepted Start.
REQ-032 AlignErr SHALL be 0 whenever Done=0.

Reset
REQ-033 Reset=1 SHALL immediately force the following, regardless of clock:
  - state IDLE
  - Busy=0, Done=0, AlignErr=0
  - Ram_Enable=0, Ram_Write=0, Ram_ByteEn=0000
  - Ram_Address=0, Ram_WData=0, MDR_DataOut=0
REQ-034 Reset asserted mid-operation SHALL abort the operation with no Done pulse; a pending ACC2 write SHALL not be issued.
REQ-035 After Reset deasserts, the first Start SHALL be accepted normally.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
  - LD, addr 0x10, RAM word 0xDEADBEEF -> one read at word 0x04; Done after 3 cycles; MDR_DataOut[63:32]=0xDEADBEEF; AlignErr=0.
  - LDSB addr 0x13 and LDUB addr 0x13, RAM word 0x000000F0 -> MDR_DataOut[63:32]=0xFFFFFFF0 and 0x000000F0 respectively.
  - STH addr 0x22, data[63:32]=0x0000ABCD -> single write, ByteEn=0011, Ram_WData=0xABCDABCD, word address 0x08.
  - STD addr 0x08, data 0x11111111_22222222 -> writes at word 0x02 then 0x03; Done after 5 cycles.
  - SWAP addr 0x04, RAM 0x12345678, data 0xCAFEF00D -> read then write 0xCAFEF00D; MDR_DataOut[63:32]=0x12345678.
  - LD addr 0x02, then illegal op 001100 -> each gives Done+AlignErr 1 cycle after Start with no Ram_Enable; Reset during WAIT1 of STD -> no ACC2 write, no Done.
